pps_phase_detector: RTL
=======================

// Module: pps_phase_detector
// PURPOSE
//  Upstream of the 1PPS divider. Measures the offset between the GPS 1PPS and the local 1PPS in CLK_Sys cycles.
//  Drives the divider's Phase_Compensate_Type/Phase_Compensate for exactly one local period, then returns them to zero.
//  Reports lock status and missing-edge conditions. Fully synchronous to CLK_Sys (10 MHz).
// PARAMETERS
//  WINDOW    5_000_000  max cycles between paired edges before the measurement is abandoned
//  DEADBAND  1          |offset| <= DEADBAND -> magnitude forced to 0
//  MAX_STEP  4095       saturation limit for Phase_Compensate (must fit 12 bits)
//  LOCK_TOL  2          |offset| <= LOCK_TOL counts as an in-tolerance measurement
//  LOCK_CNT  8          consecutive in-tolerance measurements required to set Phase_Lock
// PORTS
//  CLK_Sys                in   1   system clock, 10 MHz
//  CLK_Rst                in   1   asynchronous active-low reset
//  _1PPS_GPS              in   1   GPS 1PPS, asynchronous to CLK_Sys
//  _1PPS_Local            in   1   local 1PPS from divider (CLK_Sys domain)
//  Phase_Compensate_Type  out  1   0 = lengthen period (local early), 1 = shorten (local late)
//  Phase_Compensate       out  12  correction magnitude in cycles, unsigned
//  Phase_Valid            out  1   1-cycle pulse when a new correction is latched
//  Phase_Lock             out  1   tracking within LOCK_TOL
//  GPS_Miss               out  1   1-cycle pulse on measurement timeout
// BEHAVIOUR
//  Reset (CLK_Rst low, async): every output = 0; FSM = IDLE; offset and lock counters = 0.
//  Input conditioning:
//   - Both PPS inputs pass through an identical 2-FF sync plus edge-detect register, so path latency is equal (3 cycles).
//   - Only rising edges are used. g_rise and l_rise are single-cycle strobes.
//  FSM states and transitions:
//   - IDLE:
//     - g_rise && l_rise -> offset = 0, go to LATCH.
//     - l_rise only -> clear cnt, go to WAIT_GPS.
//     - g_rise only -> clear cnt, go to WAIT_LOC.
//   - WAIT_GPS: cnt increments each cycle.
//     - g_rise -> offset = cnt+1, Type = 0, go to LATCH.
//   - WAIT_LOC: cnt increments each cycle.
//     - l_rise -> offset = cnt+1, Type = 1, go to LATCH.
//   - Timeout: in either WAIT state, cnt reaching WINDOW-1 without the awaited edge:
//     - pulse GPS_Miss, clear Phase_Lock and the lock counter, return to IDLE.
//     - The unpaired edge is discarded.
//   - LATCH (1 cycle):
//     - Phase_Compensate = 0 if offset <= DEADBAND, else min(offset, MAX_STEP).
//     - Phase_Compensate_Type latched; Phase_Valid pulses; go to APPLY.
//     - For offset = 0, Type = 0.
//   - APPLY: outputs held stable.
//     - On the next l_rise, Phase_Compensate and Type clear to 0, go to IDLE.
//     - This l_rise also serves as the start edge of the next measurement, evaluated as in IDLE in the same cycle.
//     - g_rise during APPLY is ignored.
//  Lock:
//   - In LATCH, offset <= LOCK_TOL increments the lock counter (saturating at LOCK_CNT); otherwise counter and Phase_Lock clear.
//   - Phase_Lock = 1 when the counter reaches LOCK_CNT.
//  Widths: cnt/offset are 24-bit unsigned, never wrap (bounded by WINDOW); saturation compares at full width before truncating to 12 bits.
//  GPS absent: no g_rise ever. Each l_rise starts WAIT_GPS and times out, so GPS_Miss pulses once per second; compensation outputs stay 0.
//  Reset mid-measurement: abandons immediately; no Phase_Valid is issued.
// TESTING
//  1. Local edge 100 cycles before GPS edge -> Phase_Valid once; Type=0; Phase_Compensate=100; outputs held until next l_rise, then 0.
//  2. GPS edge 250 cycles before local edge -> Type=1; Phase_Compensate=250.
//  3. GPS leads by 6_000 cycles -> Phase_Compensate saturates at 4095, Type=1.
//  4. Edges in the same cycle, repeated 8 seconds -> Phase_Compensate=0 each time; Phase_Lock rises after the 8th Phase_Valid.
//  5. Remove GPS while locked -> GPS_Miss pulses WINDOW cycles after l_rise; Phase_Lock drops; no Phase_Valid.
//  6. Assert CLK_Rst in WAIT_GPS -> all outputs 0 immediately; after release, the next edge pair yields a correct measurement.

Source files
------------

// File: rtl/pps_phase_detector.sv
// Phase detector between the GPS 1PPS and the locally divided 1PPS.
// Measures the edge-to-edge offset in CLK_Sys cycles. The resulting correction
// drives the divider for exactly one local period. Also reports lock and
// missing-GPS conditions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no measurement open, waiting for the first edge of a pair
// WAIT_GPS | local edge seen first, counting until the GPS edge
// WAIT_LOC | GPS edge seen first, counting until the local edge
// LATCH    | one cycle: turn the offset into a correction, update lock
// APPLY    | correction held on the outputs until the next local edge
module pps_phase_detector #(
  parameter int WINDOW   = 5_000_000,
  parameter int DEADBAND = 1,
  parameter int MAX_STEP = 4095,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic        CLK_Sys,
  input  logic        CLK_Rst,
  input  logic        _1PPS_GPS,
  input  logic        _1PPS_Local,
  output logic        Phase_Compensate_Type,
  output logic [11:0] Phase_Compensate,
  output logic        Phase_Valid,
  output logic        Phase_Lock,
  output logic        GPS_Miss
);

  localparam int          LW        = $clog2(LOCK_CNT + 1);
  localparam logic [23:0] WIN_LAST  = 24'(WINDOW - 1);
  localparam logic [23:0] DB_LIM    = 24'(DEADBAND);
  localparam logic [23:0] STEP_LIM  = 24'(MAX_STEP);
  localparam logic [11:0] STEP_SAT  = 12'(MAX_STEP);
  localparam logic [23:0] TOL_LIM   = 24'(LOCK_TOL);
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_CNT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GPS,
    WAIT_LOC,
    LATCH,
    APPLY
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    gps_sync, loc_sync;
  logic          g_rise, l_rise;
  logic [23:0]   cnt, cnt_nxt;
  logic [23:0]   offset, offset_nxt;
  logic          dir, dir_nxt;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic [11:0]   comp_nxt;
  logic          comp_type_nxt, valid_nxt, lock_nxt, miss_nxt;
  logic          start_ok;

  // Identical 2-FF synchronizer plus edge register on both inputs so that
  // the GPS and local paths have the same latency and cancel in the offset.
  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      gps_sync <= '0;
      loc_sync <= '0;
    end else begin
      gps_sync <= {gps_sync[1:0], _1PPS_GPS};
      loc_sync <= {loc_sync[1:0], _1PPS_Local};
    end
  end

  assign g_rise = gps_sync[1] & ~gps_sync[2];
  assign l_rise = loc_sync[1] & ~loc_sync[2];

  // State and datapath registers; every output is registered.
  always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
    if (!CLK_Rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      offset                <= '0;
      dir                   <= 1'b0;
      lock_cnt              <= '0;
      Phase_Compensate      <= '0;
      Phase_Compensate_Type <= 1'b0;
      Phase_Valid           <= 1'b0;
      Phase_Lock            <= 1'b0;
      GPS_Miss              <= 1'b0;
    end else begin
      state                 <= state_nxt;
      cnt                   <= cnt_nxt;
      offset                <= offset_nxt;
      dir                   <= dir_nxt;
      lock_cnt              <= lock_cnt_nxt;
      Phase_Compensate      <= comp_nxt;
      Phase_Compensate_Type <= comp_type_nxt;
      Phase_Valid           <= valid_nxt;
      Phase_Lock            <= lock_nxt;
      GPS_Miss              <= miss_nxt;
    end
  end

  // Next-state and output decode. The local edge that ends APPLY is reused
  // as the opening edge of the next measurement, so APPLY shares IDLE's
  // start logic through start_ok.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    offset_nxt    = offset;
    dir_nxt       = dir;
    lock_cnt_nxt  = lock_cnt;
    comp_nxt      = Phase_Compensate;
    comp_type_nxt = Phase_Compensate_Type;
    valid_nxt     = 1'b0;
    lock_nxt      = Phase_Lock;
    miss_nxt      = 1'b0;
    start_ok      = 1'b0;

    case (state)
      IDLE: start_ok = 1'b1;

      WAIT_GPS: begin
        if (g_rise) begin
          offset_nxt = cnt + 24'd1;
          dir_nxt    = 1'b0;
          state_nxt  = LATCH;
        end else if (cnt == WIN_LAST) begin
          miss_nxt     = 1'b1;
          lock_nxt     = 1'b0;
          lock_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end

      WAIT_LOC: begin
        if (l_rise) begin
          offset_nxt = cnt + 24'd1;
          dir_nxt    = 1'b1;
          state_nxt  = LATCH;
        end else if (cnt == WIN_LAST) begin
          miss_nxt     = 1'b1;
          lock_nxt     = 1'b0;
          lock_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end

      LATCH: begin
        // Saturation is decided on the full 24-bit offset before truncation.
        if (offset <= DB_LIM)
          comp_nxt = '0;
        else if (offset > STEP_LIM)
          comp_nxt = STEP_SAT;
        else
          comp_nxt = offset[11:0];
        comp_type_nxt = dir;
        valid_nxt     = 1'b1;
        if (offset <= TOL_LIM) begin
          if (lock_cnt != LOCK_FULL)
            lock_cnt_nxt = lock_cnt + LW'(1);
          lock_nxt = (lock_cnt_nxt == LOCK_FULL);
        end else begin
          lock_cnt_nxt = '0;
          lock_nxt     = 1'b0;
        end
        state_nxt = APPLY;
      end

      APPLY: begin
        if (l_rise) begin
          comp_nxt      = '0;
          comp_type_nxt = 1'b0;
          start_ok      = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (start_ok) begin
      if (g_rise && l_rise) begin
        offset_nxt = '0;
        dir_nxt    = 1'b0;
        state_nxt  = LATCH;
      end else if (l_rise) begin
        cnt_nxt   = '0;
        state_nxt = WAIT_GPS;
      end else if (g_rise) begin
        cnt_nxt   = '0;
        state_nxt = WAIT_LOC;
      end
    end
  end

endmodule
